// File: rtl/lcd_pkg.sv
// Shared constants, hex-to-ASCII helper and frame FSM states for the LCD
// rank display.
package lcd_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_V     = 8'h56;

  localparam logic [23:0]  TXT_MIN    = 24'h4D494E;
  localparam logic [23:0]  TXT_MAX    = 24'h4D4158;
  localparam logic [127:0] BLANK_LINE = {16{ASCII_SPACE}};

  typedef enum logic [1:0] {IDLE, BUILD, OFFER} state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) return ASCII_0 + {4'd0, v};
    else           return ASCII_A + {4'd0, v} - 8'd10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer; rise pulses on the same edge the
// debounced level goes 0->1.
module btn_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYC);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          settle;

  // cnt holds how many consecutive samples so far disagreed with level; the
  // DEB_CYC-th disagreeing sample flips level on this edge.
  assign settle = (sync2 != level) && (cnt == CW'(DEB_CYC - 1));
  assign rise   = settle && sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_rank_display.sv
// Captures values into per-button slots, ranks them by min/max and offers
// two 16-char ASCII lines to an LCD controller.
module lcd_rank_display
  import lcd_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int VAL_W   = 3,
  parameter int DEB_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  value_in,
  input  logic [NUM_CH-1:0] btn,
  input  logic              mode,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [127:0]      line1,
  output logic [127:0]      line2,
  output logic [NUM_CH-1:0] entry_valid
);

  logic [NUM_CH-1:0] rise;
  logic [VAL_W-1:0]  slot [NUM_CH];
  logic              dirty;
  logic              mode_q;
  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              rank_found;
  logic [2:0]        rank_idx;
  logic [VAL_W-1:0]  rank_val;
  logic [127:0]      l1_nxt;
  logic [127:0]      l2_nxt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[k]),
      .rise (rise[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) slot[k] <= '0;
      entry_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rise[k]) begin
          slot[k]        <= value_in;
          entry_valid[k] <= 1'b1;
        end
      end
    end
  end

  // Strict comparison keeps the earliest slot on ties.
  always_comb begin
    rank_found = 1'b0;
    rank_idx   = '0;
    rank_val   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (entry_valid[k] &&
          (!rank_found || (mode ? (slot[k] > rank_val) : (slot[k] < rank_val)))) begin
        rank_found = 1'b1;
        rank_idx   = 3'(k);
        rank_val   = slot[k];
      end
    end
  end

  always_comb begin
    l1_nxt = BLANK_LINE;
    l2_nxt = BLANK_LINE;
    for (int k = 0; k < NUM_CH; k++) begin
      l1_nxt[127-24*k -: 8] = entry_valid[k] ? hex_ascii(4'(slot[k])) : ASCII_DASH;
      if (k < NUM_CH - 1) l1_nxt[119-24*k -: 8] = ASCII_COMMA;
    end
    l2_nxt[127:40] = {mode ? TXT_MAX : TXT_MIN, ASCII_SPACE, ASCII_P, ASCII_EQ,
                      rank_found ? (ASCII_0 + 8'(rank_idx)) : ASCII_DASH,
                      ASCII_SPACE, ASCII_V, ASCII_EQ,
                      rank_found ? hex_ascii(4'(rank_val)) : ASCII_DASH};
  end

  // Handshake: frame_valid is high exactly in OFFER, line1/line2 hold still
  // while it is high, and the frame is consumed on an edge with
  // frame_valid && frame_ready; frame_ready is ignored otherwise.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:    if (dirty) state_nxt = BUILD;
      BUILD: begin
        load      = 1'b1;
        state_nxt = OFFER;
      end
      OFFER:   if (frame_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_valid = (state == OFFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dirty  <= 1'b1;
      mode_q <= 1'b0;
      line1  <= BLANK_LINE;
      line2  <= BLANK_LINE;
    end else begin
      state  <= state_nxt;
      mode_q <= mode;
      // A capture or mode change wins over the clear on entry to BUILD.
      if ((|rise) || (mode != mode_q)) dirty <= 1'b1;
      else if (state == IDLE && dirty) dirty <= 1'b0;
      if (load) begin
        line1 <= l1_nxt;
        line2 <= l2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lcd_rank_display.sv
// Bench for lcd_rank_display: directed scenarios plus random button/ready
// traffic compared every cycle against a behavioural model.
module tb_lcd_rank_display;

  localparam int NUM_CH  = 4;
  localparam int VAL_W   = 3;
  localparam int DEB_CYC = 16;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [VAL_W-1:0]  value_in = '0;
  logic [NUM_CH-1:0] btn = '0;
  logic              mode = 1'b0;
  logic              frame_ready = 1'b1;
  logic              frame_valid;
  logic [127:0]      line1;
  logic [127:0]      line2;
  logic [NUM_CH-1:0] entry_valid;

  always #5 clk = ~clk;

  lcd_rank_display #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .DEB_CYC(DEB_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .btn         (btn),
    .mode        (mode),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .line1       (line1),
    .line2       (line2),
    .entry_valid (entry_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int fv_rises = 0;
  logic fv_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DEB_CYC:0]  hist [NUM_CH];
  logic [NUM_CH-1:0] m_level;
  logic [NUM_CH-1:0] m_valid;
  int                m_slot [NUM_CH];
  logic              m_mode_last;
  bit                m_req;
  bit                m_offered;
  int                m_load_t;
  int                t;
  logic [127:0]      m_l1 = BLANK;
  logic [127:0]      m_l2 = BLANK;

  function automatic logic [127:0] pack_line(input string s);
    logic [127:0] r;
    r = BLANK;
    for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] fmt_l1();
    string s;
    s = "";
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_valid[k]) s = {s, $sformatf("%0X", m_slot[k])};
      else            s = {s, "-"};
      if (k != NUM_CH - 1) s = {s, ", "};
    end
    return pack_line(s);
  endfunction

  function automatic logic [127:0] fmt_l2(input logic md);
    string s;
    int ext;
    int pos;
    ext = md ? -1 : 1000;
    pos = -1;
    for (int k = 0; k < NUM_CH; k++)
      if (m_valid[k]) ext = md ? ((m_slot[k] > ext) ? m_slot[k] : ext)
                               : ((m_slot[k] < ext) ? m_slot[k] : ext);
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (m_valid[k] && m_slot[k] == ext) pos = k;
    s = md ? "MAX P=" : "MIN P=";
    if (pos < 0) s = {s, "- V=-"};
    else         s = {s, $sformatf("%0d V=%0X", pos, ext)};
    return pack_line(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      hist[k]   = '0;
      m_slot[k] = 0;
    end
    m_level     = '0;
    m_valid     = '0;
    m_mode_last = 1'b0;
    m_req       = 1'b1;
    m_offered   = 1'b0;
    m_load_t    = -1;
    t           = 0;
    m_l1        = BLANK;
    m_l2        = BLANK;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0]  cap;
    logic [DEB_CYC-1:0] win;
    cap = '0;
    // A channel settles once the last DEB_CYC synchronized samples (btn two
    // edges late) all agree on a level different from the current one.
    for (int k = 0; k < NUM_CH; k++) begin
      win = hist[k][DEB_CYC:1];
      if (!m_level[k] && (&win)) begin
        cap[k]     = 1'b1;
        m_level[k] = 1'b1;
      end else if (m_level[k] && !(|win)) begin
        m_level[k] = 1'b0;
      end
      hist[k] = {hist[k][DEB_CYC-1:0], btn[k]};
    end
    if (m_offered && frame_ready) begin
      m_offered = 1'b0;
    end else if (m_load_t == t) begin
      m_l1      = fmt_l1();
      m_l2      = fmt_l2(mode);
      m_offered = 1'b1;
      m_load_t  = -1;
    end else if (!m_offered && m_load_t < 0 && m_req) begin
      m_load_t = t + 1;
      m_req    = 1'b0;
    end
    if ((|cap) || (mode != m_mode_last)) m_req = 1'b1;
    m_mode_last = mode;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cap[k]) begin
        m_slot[k]  = int'(value_in);
        m_valid[k] = 1'b1;
      end
    end
    t++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid && !fv_prev) fv_rises++;
      fv_prev = frame_valid;
      if (chk_on) begin
        check("cyc_frame_valid", 128'(frame_valid), 128'(m_offered));
        check("cyc_entry_valid", 128'(entry_valid), 128'(m_valid));
        check("cyc_line1", line1, m_l1);
        check("cyc_line2", line2, m_l2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int ch, input int val, input int hold);
    value_in = VAL_W'(val);
    btn[ch]  = 1'b1;
    step(hold);
    btn[ch]  = 1'b0;
    step(DEB_CYC + 6);
  endtask

  task automatic wait_fv(input string name);
    int i;
    i = 0;
    while (!frame_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (!frame_valid) begin
      n_fail++;
      $display("FAIL %s: frame_valid got 0 expected 1 within 200 cycles", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #1 rst = 1'b1;
    chk_on = 1'b1;
    step(3);
    check("reset_frame_valid", 128'(frame_valid), 128'(0));
    check("reset_line1", line1, BLANK);
    check("reset_line2", line2, BLANK);

    // First frame after release is blank, then nothing more.
    base = fv_rises;
    rst  = 1'b0;
    wait_fv("first_frame");
    check("first_line1", line1, "-, -, -, -      ");
    check("first_line2", line2, "MIN P=- V=-     ");
    step(10);
    check("first_one_frame", 128'(fv_rises - base), 128'(1));

    // Four captures, min mode, tie goes to slot 1.
    press(0, 5, 20);
    press(1, 2, 20);
    press(2, 7, 20);
    press(3, 2, 20);
    step(5);
    check("cap_line1", line1, "5, 2, 7, 2      ");
    check("cap_line2", line2, "MIN P=1 V=2     ");

    mode = 1'b1;
    step(6);
    check("max_line1", line1, "5, 2, 7, 2      ");
    check("max_line2", line2, "MAX P=2 V=7     ");

    // Short glitch is filtered.
    base = fv_rises;
    value_in = 3'd1;
    btn[1] = 1'b1;
    step(3);
    btn[1] = 1'b0;
    step(30);
    check("glitch_no_frame", 128'(fv_rises - base), 128'(0));
    check("glitch_line1", line1, "5, 2, 7, 2      ");

    // Long press: capture at debounced edge, frame two edges later.
    value_in = 3'd4;
    btn[1] = 1'b1;
    step(DEB_CYC + 2);
    check("lat_slot_valid", 128'(entry_valid), 128'(4'b1111));
    step(1);
    check("lat_e1_no_frame", 128'(frame_valid), 128'(0));
    step(1);
    check("lat_e2_frame", 128'(frame_valid), 128'(1));
    check("lat_line1", line1, "5, 4, 7, 2      ");
    step(2);
    btn[1] = 1'b0;
    step(DEB_CYC + 6);

    // Capture while offered leaves the frame alone, then yields one more.
    frame_ready = 1'b0;
    mode = 1'b0;
    step(4);
    check("hold_fv", 128'(frame_valid), 128'(1));
    check("hold_line2", line2, "MIN P=3 V=2     ");
    base = fv_rises;
    press(0, 3, 20);
    check("hold_line1_stable", line1, "5, 4, 7, 2      ");
    check("hold_fv_still", 128'(frame_valid), 128'(1));
    frame_ready = 1'b1;
    step(30);
    check("after_one_frame", 128'(fv_rises - base), 128'(1));
    check("after_line1", line1, "3, 4, 7, 2      ");
    check("after_line2", line2, "MIN P=3 V=2     ");

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 29) == 0) btn[k] = ~btn[k];
      value_in = VAL_W'($urandom);
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      frame_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    btn = '0;
    frame_ready = 1'b1;
    mode = 1'b0;
    step(60);

    // Reset in the middle of an offered frame.
    frame_ready = 1'b0;
    value_in = 3'd6;
    btn[2] = 1'b1;
    step(20);
    btn[2] = 1'b0;
    wait_fv("pre_reset_offer");
    step(1);
    rst = 1'b1;
    #1;
    check("rst_mid_fv", 128'(frame_valid), 128'(0));
    check("rst_mid_line1", line1, BLANK);
    step(2);
    rst = 1'b0;
    frame_ready = 1'b1;
    wait_fv("post_reset_frame");
    check("post_rst_line1", line1, "-, -, -, -      ");
    check("post_rst_line2", line2, "MIN P=- V=-     ");
    step(10);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_rank_display.md
LCD_RANK_DISPLAY -- requirements
Module: lcd_rank_display

Interface
REQ-001 Parameter NUM_CH, default 4, number of capture channels, legal range 2..5.
REQ-002 Parameter VAL_W, default 3, captured value width, legal range 1..4.
REQ-003 Parameter DEB_CYC, default 16, debounce length in clk cycles, legal range ≥2.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 value_in  in  VAL_W  value to capture; sampled on clk, no synchronizer.
REQ-007 btn  in  NUM_CH  raw asynchronous push-buttons; btn[k] captures into slot k.
REQ-008 mode  in  1  0 = rank by minimum, 1 = rank by maximum; quasi-static.
REQ-009 frame_ready  in  1  downstream LCD controller accepts the offered frame.
REQ-010 frame_valid  out  1  line1 and line2 hold a frame awaiting acceptance.
REQ-011 line1  out  128  16 ASCII chars, MSB byte is column 0.
REQ-012 line2  out  128  16 ASCII chars, MSB byte is column 0.
REQ-013 entry_valid  out  NUM_CH  slot k holds a captured value.

Function
REQ-014 Each btn[k] SHALL pass through a 2-flop synchronizer, then a debouncer that changes its level only after DEB_CYC consecutive equal synchronized samples.
REQ-015 A debounced 0->1 edge on channel k SHALL load value_in into slot k and set entry_valid[k] on the same clock edge. 1->0 edges SHALL have no effect.
REQ-016 Simultaneous edges on several channels SHALL all capture the same value_in. Recapture SHALL overwrite the slot.
REQ-017 Ranking SHALL consider valid slots only. Ties SHALL go to the lowest index. With no valid slot, rank SHALL be "none".
REQ-018 Digits SHALL be hex ASCII: '0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46. Values SHALL be zero-extended to 4 bits.
REQ-019 line1 SHALL hold, per slot k: the digit, or '-' (0x2D) if invalid, followed by ", " except after the last slot. Remaining columns SHALL be space (0x20).
REQ-020 line2 SHALL be "MIN P=p V=v" or "MAX P=p V=v", with p the decimal slot index and v the hex value. For "none", p and v SHALL be '-'. Padding SHALL be spaces.
REQ-021 A dirty flag SHALL be set by any capture or any mode change. It SHALL be cleared on entry to BUILD.
REQ-022 FSM IDLE: go to BUILD if dirty, else stay.
REQ-023 FSM BUILD: one cycle; the next edge SHALL load line1/line2 from current slots and mode, then go to OFFER.
REQ-024 FSM OFFER: frame_valid=1. line1/line2 SHALL stay stable. On an edge with frame_ready=1, go to IDLE and drop frame_valid.
REQ-025 Latency: capture at edge E -> BUILD after E+1 -> frame_valid=1 after E+2, when the FSM was in IDLE at E.
REQ-026 Captures during BUILD or OFFER SHALL update the slots and set dirty but SHALL NOT alter the offered frame. They SHALL produce exactly one further frame after acceptance.
REQ-027 A capture on the same edge as the BUILD load SHALL be excluded from that frame. dirty SHALL remain set.
REQ-028 frame_ready while not in OFFER SHALL be ignored.

Reset
REQ-029 rst=1 SHALL asynchronously clear:
- all slots and entry_valid
- synchronizer, debounce counters and debounced levels
- frame_valid
- state, forced to IDLE.
REQ-030 During reset, line1 and line2 SHALL be all spaces.
REQ-031 dirty SHALL reset to 1, so the first frame after release is "-, -, -, -" / "MIN P=- V=-" (mode=0).
REQ-032 Reset asserted in OFFER SHALL abandon the frame without a handshake.

Structure
REQ-033 Shared package lcd_pkg SHALL hold:
- ASCII constants (space, comma, dash, '0', 'A')
- the hex-to-ASCII function
- the FSM state enum {IDLE, BUILD, OFFER}.
REQ-034 Sub-module btn_debounce (synchronizer + debounce counter, parameter DEB_CYC) SHALL be instantiated once per channel.

Verification
REQ-035 Reset release, no buttons, frame_ready=1 -> one frame "-, -, -, -" / "MIN P=- V=-", then frame_valid stays 0.
REQ-036 Captures 5,2,7,2 on ch0..3, mode=0 -> line1 "5, 2, 7, 2"; line2 "MIN P=1 V=2" (tie to lowest index).
REQ-037 Toggle mode to 1 with no capture -> a new frame with line2 "MAX P=2 V=7" and line1 unchanged.
REQ-038 Button held 3 cycles with DEB_CYC=16 -> no capture and no frame. Held 20 cycles -> capture occurs, frame_valid at debounced edge +2.
REQ-039 frame_ready held 0, capture ch0=3 during OFFER -> offered lines stable. After frame_ready, exactly one more frame shows "3, ...".
REQ-040 rst pulsed mid-OFFER -> frame_valid=0 immediately; the next frame is blank, as in REQ-035.
